seq_updn_fsm: RTL

SEQ_UPDN_FSM -- requirements
Module: seq_updn_fsm

---
 rtl/seq_updn_fsm.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_updn_fsm.sv
// seq_updn_fsm
//   Modulo-MOD up/down state sequencer with a wrap or saturate end mode,
//   a clamped synchronous load, a Moore match decode and a saturating
//   counter of entries into the match state.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   step enable
//   A         in   direction: 0 = up (+1), 1 = down (-1)
//   sat       in   end mode: 0 = wrap, 1 = saturate at 0 and MOD-1
//   ld        in   synchronous load strobe (beats en)
//   ld_val    in   [W-1:0] load value, clamped to MOD-1
//   clr_hits  in   synchronous clear of hits
//   state     out  [W-1:0] current state
//   Y         out  high while state == MATCH
//   wrap      out  one-cycle pulse after a wrapping step
//   hits      out  [HW-1:0] saturating count of entries into MATCH
module seq_updn_fsm #(
  parameter int W     = 2,
  parameter int MOD   = 4,
  parameter int MATCH = 3,
  parameter int HW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          A,
  input  logic          sat,
  input  logic          ld,
  input  logic [W-1:0]  ld_val,
  input  logic          clr_hits,
  output logic [W-1:0]  state,
  output logic          Y,
  output logic          wrap,
  output logic [HW-1:0] hits
);

  localparam logic [W-1:0]  ZERO_W   = W'(0);
  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [W-1:0]  MAX_W    = W'(MOD - 1);
  localparam logic [W-1:0]  MATCH_W  = W'(MATCH);
  // One extra bit so MOD == 2**W still compares correctly.
  localparam logic [W:0]    MOD_X    = (W+1)'(MOD);
  localparam logic [HW-1:0] HITS_ONE = HW'(1);
  localparam logic [HW-1:0] HITS_MAX = {HW{1'b1}};

  logic [W-1:0]  state_r;
  logic          wrap_r;
  logic [HW-1:0] hits_r;

  logic [W-1:0]  nxt_state_s;
  logic          nxt_wrap_s;
  logic [HW-1:0] nxt_hits_s;
  logic          entry_s;

  // State, wrap pulse and hit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ZERO_W;
      wrap_r  <= 1'b0;
      hits_r  <= {HW{1'b0}};
    end else begin
      state_r <= nxt_state_s;
      wrap_r  <= nxt_wrap_s;
      hits_r  <= nxt_hits_s;
    end
  end

  // Next state: load beats step beats hold; wrap flagged only on a real wrap.
  always_comb begin
    nxt_state_s = state_r;
    nxt_wrap_s  = 1'b0;
    if (ld) begin
      if ({1'b0, ld_val} >= MOD_X) begin
        nxt_state_s = MAX_W;
      end else begin
        nxt_state_s = ld_val;
      end
    end else if (en) begin
      if (!A) begin
        if (state_r == MAX_W) begin
          if (sat) begin
            nxt_state_s = state_r;
          end else begin
            nxt_state_s = ZERO_W;
            nxt_wrap_s  = 1'b1;
          end
        end else begin
          nxt_state_s = state_r + ONE_W;
        end
      end else begin
        if (state_r == ZERO_W) begin
          if (sat) begin
            nxt_state_s = state_r;
          end else begin
            nxt_state_s = MAX_W;
            nxt_wrap_s  = 1'b1;
          end
        end else begin
          nxt_state_s = state_r - ONE_W;
        end
      end
    end else begin
      nxt_state_s = state_r;
    end
  end

  // Hit counter: an entry is any transition into MATCH from elsewhere.
  always_comb begin
    entry_s    = (nxt_state_s == MATCH_W) && (state_r != MATCH_W);
    nxt_hits_s = hits_r;
    if (clr_hits) begin
      if (entry_s) begin
        nxt_hits_s = HITS_ONE;
      end else begin
        nxt_hits_s = {HW{1'b0}};
      end
    end else if (entry_s && (hits_r != HITS_MAX)) begin
      nxt_hits_s = hits_r + HITS_ONE;
    end else begin
      nxt_hits_s = hits_r;
    end
  end

  // Outputs: Y decoded from the state register only.
  always_comb begin
    state = state_r;
    Y     = (state_r == MATCH_W);
    wrap  = wrap_r;
    hits  = hits_r;
  end

endmodule
